fpu_arith_dispatcher: RTL and testbench

- Request/response front end sitting directly upstream of the FPU arithmetic unit.
- Accepts one operation per valid/ready handshake from the FPU core control sequencer.
- Drives the arithmetic unit's operation/enable/operand interface, holding operands stable, and waits for the unit's done pulse with a timeout.
- Returns the result, flags and condition codes as one response beat (two beats for FSINCOS: sin first, then cos).

---
 rtl/fpu_arith_dispatcher.sv | 179 +++++++++++++++++
 tb/tb_fpu_arith_dispatcher.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_arith_dispatcher.sv
// Request/response front end for the FPU arithmetic unit: one operation in flight,
// a one-cycle start pulse, a bounded wait for done, then one or two response beats.
module fpu_arith_dispatcher #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [1:0]  req_rmode,
    input  logic [79:0] req_a,
    input  logic [79:0] req_b,
    output logic [3:0]  au_operation,
    output logic        au_enable,
    output logic [1:0]  au_rounding_mode,
    output logic [79:0] au_operand_a,
    output logic [79:0] au_operand_b,
    output logic [15:0] au_int16_in,
    output logic [31:0] au_int32_in,
    output logic [31:0] au_fp32_in,
    output logic [63:0] au_fp64_in,
    input  logic [79:0] au_result,
    input  logic [79:0] au_result_secondary,
    input  logic        au_has_secondary,
    input  logic [15:0] au_int16_out,
    input  logic [31:0] au_int32_out,
    input  logic [31:0] au_fp32_out,
    input  logic [63:0] au_fp64_out,
    input  logic        au_done,
    input  logic [5:0]  au_flags,
    input  logic [3:0]  au_cc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [79:0] rsp_data,
    output logic        rsp_last,
    output logic [5:0]  rsp_flags,
    output logic [3:0]  rsp_cc,
    output logic        rsp_timeout,
    output logic        busy
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP_P, S_RESP_S} state_t;

    localparam logic [3:0]       OP_TO_INT16 = 4'd6;
    localparam logic [3:0]       OP_TO_INT32 = 4'd7;
    localparam logic [3:0]       OP_TO_FP32  = 4'd10;
    localparam logic [3:0]       OP_TO_FP64  = 4'd11;
    localparam logic [3:0]       OP_SINCOS   = 4'd15;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       op_q;
    logic [1:0]       rmode_q;
    logic [79:0]      a_q, b_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [79:0]      data_q, sec_q, data_cap;
    logic [5:0]       flags_q;
    logic [3:0]       cc_q;
    logic             timeout_q, sec_pending_q;
    logic             timeout_hit;

    // The threshold is checked against the incremented count; a done in the same cycle wins.
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = !au_done && (cnt_inc == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = S_ISSUE;
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (au_done || timeout_hit) state_d = S_RESP_P;
            end
            S_RESP_P: if (rsp_ready) state_d = sec_pending_q ? S_RESP_S : S_IDLE;
            S_RESP_S: if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        au_enable = 1'b0;
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_ISSUE: au_enable = 1'b1;
            S_RESP_P: begin
                rsp_valid = 1'b1;
                rsp_last  = !sec_pending_q;
            end
            S_RESP_S: begin
                rsp_valid = 1'b1;
                rsp_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_TO_INT16: data_cap = {{64{au_int16_out[15]}}, au_int16_out};
            OP_TO_INT32: data_cap = {{48{au_int32_out[31]}}, au_int32_out};
            OP_TO_FP32:  data_cap = {48'd0, au_fp32_out};
            OP_TO_FP64:  data_cap = {16'd0, au_fp64_out};
            default:     data_cap = au_result;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q          <= '0;
            rmode_q       <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            data_q        <= '0;
            sec_q         <= '0;
            flags_q       <= '0;
            cc_q          <= '0;
            timeout_q     <= 1'b0;
            sec_pending_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == S_IDLE && req_valid) begin
                op_q    <= req_op;
                rmode_q <= req_rmode;
                a_q     <= req_a;
                b_q     <= req_b;
            end
            if (state_q == S_WAIT) begin
                if (au_done) begin
                    data_q        <= data_cap;
                    sec_q         <= au_result_secondary;
                    flags_q       <= au_flags;
                    cc_q          <= au_cc;
                    timeout_q     <= 1'b0;
                    sec_pending_q <= au_has_secondary && (op_q == OP_SINCOS);
                end else if (timeout_hit) begin
                    data_q        <= '0;
                    flags_q       <= 6'b100000;
                    cc_q          <= 4'b0001;
                    timeout_q     <= 1'b1;
                    sec_pending_q <= 1'b0;
                end
            end
        end
    end

    assign au_operation     = op_q;
    assign au_rounding_mode = rmode_q;
    assign au_operand_a     = a_q;
    assign au_operand_b     = b_q;
    assign au_int16_in      = a_q[15:0];
    assign au_int32_in      = a_q[31:0];
    assign au_fp32_in       = a_q[31:0];
    assign au_fp64_in       = a_q[63:0];

    assign rsp_data    = (state_q == S_RESP_S) ? sec_q : data_q;
    assign rsp_flags   = flags_q;
    assign rsp_cc      = cc_q;
    assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_fpu_arith_dispatcher.sv
// Bench for fpu_arith_dispatcher: a latency-programmable arithmetic-unit stub plus a
// reference model of the response each request should produce.
module tb_fpu_arith_dispatcher;
    localparam int TO_CYC = 16;
    localparam logic [3:0] OP_ADD = 4'd0, OP_MUL = 4'd2, OP_TO_INT16 = 4'd6, OP_SINCOS = 4'd15;

    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [3:0]  req_op = '0;
    logic [1:0]  req_rmode = '0;
    logic [79:0] req_a = '0, req_b = '0;
    logic [3:0]  au_operation;
    logic        au_enable;
    logic [1:0]  au_rounding_mode;
    logic [79:0] au_operand_a, au_operand_b;
    logic [15:0] au_int16_in;
    logic [31:0] au_int32_in, au_fp32_in;
    logic [63:0] au_fp64_in;
    logic [79:0] au_result = '0, au_result_secondary = '0;
    logic        au_has_secondary = 1'b0;
    logic [15:0] au_int16_out = '0;
    logic [31:0] au_int32_out = '0, au_fp32_out = '0;
    logic [63:0] au_fp64_out = '0;
    logic        au_done = 1'b0;
    logic [5:0]  au_flags = '0;
    logic [3:0]  au_cc = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_last, rsp_timeout, busy;
    logic [79:0] rsp_data;
    logic [5:0]  rsp_flags;
    logic [3:0]  rsp_cc;

    int total = 0, bad = 0;
    int stub_lat = 1, stub_cnt = 0, enable_count = 0;
    bit hold_err = 0;
    logic [3:0]  seen_op;
    logic [1:0]  seen_rm;
    logic [79:0] seen_a, seen_b;
    logic [15:0] seen_i16;
    logic [31:0] seen_i32, seen_f32;
    logic [63:0] seen_f64;
    logic [79:0] beat_data [2];

    fpu_arith_dispatcher #(.TIMEOUT_CYCLES(TO_CYC), .CNT_W(11)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rmode(req_rmode),
        .req_a(req_a), .req_b(req_b),
        .au_operation(au_operation), .au_enable(au_enable), .au_rounding_mode(au_rounding_mode),
        .au_operand_a(au_operand_a), .au_operand_b(au_operand_b),
        .au_int16_in(au_int16_in), .au_int32_in(au_int32_in), .au_fp32_in(au_fp32_in),
        .au_fp64_in(au_fp64_in),
        .au_result(au_result), .au_result_secondary(au_result_secondary),
        .au_has_secondary(au_has_secondary), .au_int16_out(au_int16_out),
        .au_int32_out(au_int32_out), .au_fp32_out(au_fp32_out), .au_fp64_out(au_fp64_out),
        .au_done(au_done), .au_flags(au_flags), .au_cc(au_cc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .rsp_flags(rsp_flags), .rsp_cc(rsp_cc), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stub arithmetic unit: done pulses stub_lat cycles after the enable (0 = never).
    initial begin
        forever begin
            @(negedge clk);
            au_done = 1'b0;
            if (reset) begin
                stub_cnt = 0;
            end else if (au_enable) begin
                enable_count++;
                stub_cnt = stub_lat;
                seen_op = au_operation; seen_rm = au_rounding_mode;
                seen_a = au_operand_a;  seen_b = au_operand_b;
                seen_i16 = au_int16_in; seen_i32 = au_int32_in;
                seen_f32 = au_fp32_in;  seen_f64 = au_fp64_in;
            end else begin
                if (busy && ({au_operation, au_rounding_mode, au_operand_a, au_operand_b, au_fp64_in}
                             !== {seen_op, seen_rm, seen_a, seen_b, seen_f64}))
                    hold_err = 1;
                if (stub_cnt > 0) begin
                    stub_cnt--;
                    if (stub_cnt == 0) au_done = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [79:0] rand80();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[79:0];
    endfunction

    task automatic rand_au();
        au_result = rand80(); au_result_secondary = rand80();
        au_has_secondary = 1'($urandom());
        au_int16_out = 16'($urandom()); au_int32_out = $urandom();
        au_fp32_out = $urandom(); au_fp64_out = {$urandom(), $urandom()};
        au_flags = 6'($urandom()); au_cc = 4'($urandom());
    endtask

    // Primary response value the dispatcher should return for a completed op.
    function automatic logic [79:0] model_primary(input logic [3:0] op);
        logic signed [79:0] v;
        case (op)
            4'd6:    begin v = $signed(au_int16_out); return v; end
            4'd7:    begin v = $signed(au_int32_out); return v; end
            4'd10:   return {48'd0, au_fp32_out};
            4'd11:   return {16'd0, au_fp64_out};
            default: return au_result;
        endcase
    endfunction

    task automatic run_txn(input logic [3:0] op, input logic [1:0] rm, input logic [79:0] a,
                           input logic [79:0] b, input int lat, input int stall, input bit poke);
        logic [79:0] exp_d [2];
        logic [5:0]  ef;
        logic [3:0]  ecc;
        bit          to, sec;
        int          n, beats, ec0, exp_lat;
        // The unit has TO_CYC-1 wait cycles to answer; later (or never) means timeout.
        to      = (lat == 0) || (lat > TO_CYC - 1);
        sec     = !to && au_has_secondary && (op == OP_SINCOS);
        exp_d[0] = to ? 80'd0 : model_primary(op);
        exp_d[1] = au_result_secondary;
        ef      = to ? 6'b100000 : au_flags;
        ecc     = to ? 4'b0001 : au_cc;
        beats   = sec ? 2 : 1;
        exp_lat = to ? TO_CYC + 1 : lat + 2;
        stub_lat = lat;
        rsp_ready = (stall == 0);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        ec0 = enable_count; hold_err = 0;
        req_valid = 1'b1; req_op = op; req_rmode = rm; req_a = a; req_b = b;
        @(negedge clk);
        req_valid = 1'b0; req_a = rand80(); req_b = rand80();
        total++;
        if ({busy, au_enable, req_ready} !== 3'b110)
            $display("FAIL accept op=%0d got busy/en/rdy=%b%b%b exp=110", op, busy, au_enable, req_ready);
        n = 1;
        while (!rsp_valid && n < TO_CYC + 20) begin @(negedge clk); n++; end
        total++;
        if (n !== exp_lat) begin
            bad++; $display("FAIL latency op=%0d got=%0d exp=%0d", op, n, exp_lat);
        end
        for (int k = 0; k < beats; k++) begin
            n = 0;
            while (!rsp_valid && n < 5) begin @(negedge clk); n++; end
            if (poke && k == 0) begin
                req_valid = 1'b1; req_op = 4'd1; req_a = rand80();
            end
            for (int s = 0; s < stall && k == 0; s++) begin
                total++;
                if ({rsp_valid, rsp_data, rsp_flags, rsp_cc, rsp_timeout, req_ready}
                    !== {1'b1, exp_d[0], ef, ecc, to, 1'b0}) begin
                    bad++; $display("FAIL stall_hold cyc=%0d got data=%h flags=%b rdy=%b exp data=%h flags=%b rdy=0",
                                    s, rsp_data, rsp_flags, req_ready, exp_d[0], ef);
                end
                @(negedge clk);
            end
            rsp_ready = 1'b1;
            beat_data[k] = rsp_data;
            total++;
            if (rsp_data !== exp_d[k]) begin
                bad++; $display("FAIL data op=%0d beat=%0d got=%h exp=%h", op, k, rsp_data, exp_d[k]);
            end
            total++;
            if ({rsp_valid, rsp_last, rsp_flags, rsp_cc, rsp_timeout, req_ready}
                !== {1'b1, k == beats - 1, ef, ecc, to, 1'b0}) begin
                bad++; $display("FAIL beat_ctl op=%0d beat=%0d got v/l/f/cc/to/rdy=%b %b %b %b %b %b exp 1 %b %b %b %b 0",
                                op, k, rsp_valid, rsp_last, rsp_flags, rsp_cc, rsp_timeout, req_ready,
                                k == beats - 1, ef, ecc, to);
            end
            @(negedge clk);
        end
        total++;
        if ({busy, req_ready, rsp_valid} !== 3'b010) begin
            bad++; $display("FAIL back_idle op=%0d got busy/rdy/vld=%b%b%b exp=010", op, busy, req_ready, rsp_valid);
        end
        total++;
        if (enable_count - ec0 !== 1 || hold_err !== 0) begin
            bad++; $display("FAIL enable_hold op=%0d got pulses=%0d hold_err=%0d exp pulses=1 hold_err=0",
                            op, enable_count - ec0, hold_err);
        end
        total++;
        if ({seen_op, seen_rm, seen_a, seen_b, seen_i16, seen_i32, seen_f32, seen_f64}
            !== {op, rm, a, b, a[15:0], a[31:0], a[31:0], a[63:0]}) begin
            bad++; $display("FAIL operands op=%0d got op=%0d rm=%0d a=%h b=%h f64=%h exp op=%0d rm=%0d a=%h b=%h",
                            op, seen_op, seen_rm, seen_a, seen_b, seen_f64, op, rm, a, b);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, rsp_valid, au_enable, req_ready, rsp_last, rsp_timeout} !== 6'b000100) begin
            bad++; $display("FAIL reset_ctl got=%b exp=000100",
                            {busy, rsp_valid, au_enable, req_ready, rsp_last, rsp_timeout});
        end
        total++;
        if ({rsp_data, rsp_flags, rsp_cc, au_operation, au_operand_a, au_operand_b} !== '0) begin
            bad++; $display("FAIL reset_data got data=%h flags=%b cc=%b opa=%h exp all zero",
                            rsp_data, rsp_flags, rsp_cc, au_operand_a);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        rand_au();
        au_result = 80'h4000C000000000000000; au_flags = 6'd0; au_has_secondary = 1'b1;
        run_txn(OP_ADD, 2'd0, 80'h3FFF8000000000000000, 80'h40008000000000000000, 3, 0, 0);
        total++;
        if (beat_data[0] !== 80'h4000C000000000000000) begin
            bad++; $display("FAIL add_value got=%h exp=4000c000000000000000", beat_data[0]);
        end
    endtask

    task automatic test_int16();
        rand_au();
        au_int16_out = 16'hFFFB;
        run_txn(OP_TO_INT16, 2'd0, 80'hC001A000000000000000, rand80(), 2, 0, 0);
        total++;
        if (beat_data[0] !== 80'hFFFF_FFFF_FFFF_FFFF_FFFB) begin
            bad++; $display("FAIL int16_sext got=%h exp=fffffffffffffffffffb", beat_data[0]);
        end
    endtask

    task automatic test_sincos();
        rand_au();
        au_result = 80'd0; au_result_secondary = 80'h3FFF8000000000000000; au_has_secondary = 1'b1;
        run_txn(OP_SINCOS, 2'd0, 80'd0, 80'd0, 4, 0, 0);
        total++;
        if ({beat_data[0], beat_data[1]} !== {80'd0, 80'h3FFF8000000000000000}) begin
            bad++; $display("FAIL sincos got sin=%h cos=%h exp sin=0 cos=3fff8000000000000000",
                            beat_data[0], beat_data[1]);
        end
    endtask

    task automatic test_timeout();
        rand_au(); au_has_secondary = 1'b1;
        run_txn(OP_SINCOS, 2'd3, rand80(), rand80(), 0, 0, 0);
        rand_au();
        run_txn(OP_MUL, 2'd1, rand80(), rand80(), TO_CYC - 1, 0, 0);
        rand_au();
        run_txn(4'd11, 2'd2, rand80(), rand80(), TO_CYC, 0, 0);
    endtask

    task automatic test_backpressure();
        int n;
        rand_au();
        run_txn(OP_MUL, 2'd1, rand80(), rand80(), 3, 10, 1);
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if ({au_enable, au_operation} !== {1'b1, 4'd1}) begin
            bad++; $display("FAIL bp_accept got en=%b op=%0d exp en=1 op=1", au_enable, au_operation);
        end
        n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL bp_drain got busy=%b exp=0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int ec;
        stub_lat = 0;
        req_valid = 1'b1; req_op = OP_MUL; req_a = rand80(); req_b = rand80();
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({busy, rsp_valid, au_enable, req_ready} !== 4'b0001) begin
            bad++; $display("FAIL reset_mid got busy/vld/en/rdy=%b exp=0001",
                            {busy, rsp_valid, au_enable, req_ready});
        end
        @(negedge clk);
        reset = 1'b0;
        ec = enable_count;
        repeat (4) @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || enable_count !== ec) begin
            bad++; $display("FAIL reset_quiet got vld=%b pulses=%0d exp vld=0 pulses=0",
                            rsp_valid, enable_count - ec);
        end
        rand_au();
        run_txn(OP_ADD, 2'd0, rand80(), rand80(), 2, 0, 0);
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            rand_au();
            op = (i % 4 == 0) ? OP_SINCOS : 4'($urandom_range(15));
            run_txn(op, 2'($urandom()), rand80(), rand80(), $urandom_range(1, 8),
                    $urandom_range(0, 3), 0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_int16();
        test_sincos();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
